cwmac_req_arbiter: RTL

//  Shares one CWMACOpt tag engine among NREQ requesters (e.g. the DRAM-side

---
 rtl/cwmac_req_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cwmac_req_arbiter.sv
// Round-robin front end that shares one CWMACOpt tag engine among NREQ requesters,
// one MAC operation in flight, with a watchdog that answers a hung engine with an error.
module cwmac_req_arbiter #(
   parameter int NREQ    = 2,
   parameter int ADDR_W  = 26,
   parameter int NONCE_W = 56,
   parameter int MSG_W   = 512,
   parameter int TAG_W   = 56,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*NONCE_W-1:0]  req_nonce,
   input  logic [NREQ*MSG_W-1:0]    req_msg,
   output logic [NREQ-1:0]          rsp_valid,
   input  logic [NREQ-1:0]          rsp_ready,
   output logic [TAG_W-1:0]         rsp_tag,
   output logic                     rsp_err,
   output logic                     mac_src_valid,
   output logic [ADDR_W-1:0]        mac_src_addr,
   output logic [NONCE_W-1:0]       mac_src_nonce,
   output logic [MSG_W-1:0]         mac_src_msg,
   input  logic [TAG_W-1:0]         mac_tag,
   input  logic                     mac_tag_valid,
   output logic                     mac_tag_ready,
   output logic                     busy,
   output logic [$clog2(NREQ)-1:0]  owner
);

   localparam int OWN_W = $clog2(NREQ);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [NONCE_W-1:0] nonce;
      logic [MSG_W-1:0]   msg;
   } mac_req_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t             state, state_nxt;
   mac_req_t           req_lane [NREQ];
   mac_req_t           lat;
   logic [OWN_W-1:0]   rr_ptr, owner_q, grant_idx;
   logic [OWN_W:0]     cand;
   logic               grant_any;
   logic [TMR_W-1:0]   timer;
   logic [TAG_W-1:0]   tag_q;
   logic               err_q;
   logic               take_req, take_tag, take_tmo, rsp_done;

   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      assign req_lane[i] = {req_addr[i*ADDR_W +: ADDR_W],
                            req_nonce[i*NONCE_W +: NONCE_W],
                            req_msg[i*MSG_W +: MSG_W]};
   end

   // First valid requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr} + (OWN_W+1)'(k);
         if (cand >= (OWN_W+1)'(NREQ))
            cand = cand - (OWN_W+1)'(NREQ);
         if (!grant_any && req_valid[cand[OWN_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[OWN_W-1:0];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      req_ready     = '0;
      rsp_valid     = '0;
      mac_src_valid = 1'b0;
      mac_tag_ready = 1'b0;
      take_req      = 1'b0;
      take_tag      = 1'b0;
      take_tmo      = 1'b0;
      rsp_done      = 1'b0;
      unique case (state)
         IDLE: begin
            // Hold the grant off while reset is asserted so every output reads 0.
            if (grant_any && !reset) begin
               req_ready[grant_idx] = 1'b1;
               take_req             = 1'b1;
               state_nxt            = ISSUE;
            end
         end
         ISSUE: begin
            mac_src_valid = 1'b1;
            state_nxt     = WAIT;
         end
         WAIT: begin
            mac_tag_ready = mac_tag_valid;
            if (mac_tag_valid) begin
               take_tag  = 1'b1;
               state_nxt = RESP;
            end else if (timer == TMR_W'(TIMEOUT)) begin
               take_tmo  = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid[owner_q] = 1'b1;
            if (rsp_ready[owner_q]) begin
               rsp_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lat     <= '0;
         owner_q <= '0;
         rr_ptr  <= '0;
         timer   <= '0;
         tag_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (take_req) begin
            lat     <= req_lane[grant_idx];
            owner_q <= grant_idx;
         end
         if (state == ISSUE)
            timer <= '0;
         else if (state == WAIT && !take_tag && !take_tmo)
            timer <= timer + 1'b1;
         if (take_tag) begin
            tag_q <= mac_tag;
            err_q <= 1'b0;
         end
         if (take_tmo) begin
            tag_q <= '0;
            err_q <= 1'b1;
         end
         if (rsp_done)
            rr_ptr <= (owner_q == OWN_W'(NREQ-1)) ? '0 : owner_q + 1'b1;
      end
   end

   assign mac_src_addr  = lat.addr;
   assign mac_src_nonce = lat.nonce;
   assign mac_src_msg   = lat.msg;
   assign rsp_tag       = tag_q;
   assign rsp_err       = err_q;
   assign busy          = (state != IDLE);
   assign owner         = owner_q;

endmodule
